// File: rtl/lc3_kb_pkg.sv
// rtl/lc3_kb_pkg.sv - shared types and constants for the LC-3 serial keyboard receiver
package lc3_kb_pkg;

  localparam int CHAR_W      = 8;
  localparam int DEFAULT_DIV = 434;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE  = ST_IDLE,
    RX_START = ST_START,
    RX_DATA  = ST_DATA,
    RX_STOP  = ST_STOP,
    RX_BREAK = ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/lc3_sync_fifo.sv
// rtl/lc3_sync_fifo.sv - circular character FIFO, drops pushes when full
// When empty, a simultaneous push and pop passes the pushed word straight to o_head.
module lc3_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && (!o_empty || i_push);
  assign o_head    = o_empty ? i_push_data : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lc3_uart_kb_rx.sv
// rtl/lc3_uart_kb_rx.sv - 8N1 serial receiver feeding the LC-3 KBDR/KBSR stage
// Holds the rx synchronizer, receiver FSM and KBSR-gated delivery of buffered characters.
module lc3_uart_kb_rx
  import lc3_kb_pkg::*;
#(
  parameter int DIV        = DEFAULT_DIV,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  kb_full,
  input  logic                  clr_err,
  output logic [CHAR_W-1:0]     I_char,
  output logic                  LD_char,
  output logic                  overrun,
  output logic                  frame_err,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(DIV - 1);

  logic              r_sync1;
  logic              r_sync2;
  rx_state_e         r_state;
  logic [15:0]       r_cnt;
  logic [2:0]        r_idx;
  logic [CHAR_W-1:0] r_shift;
  logic              r_ld;
  logic [CHAR_W-1:0] r_char;
  logic              r_ovr;
  logic              r_ferr;

  logic              w_rxs;
  logic              w_expire;
  logic              w_push;
  logic              w_bad_stop;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CHAR_W-1:0] w_head;
  logic [DEPTH_LOG2:0] w_count;

  assign w_rxs      = r_sync2;
  assign w_expire   = (r_cnt == 16'd0);
  assign w_push     = (r_state == RX_STOP) && w_expire && w_rxs;
  assign w_bad_stop = (r_state == RX_STOP) && w_expire && !w_rxs;
  // Holdoff on r_ld gives KBSR[15] one edge to rise after each load.
  assign w_pop      = (!w_empty || w_push) && !kb_full && !r_ld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (!w_rxs) begin
            r_state <= RX_START;
            r_cnt   <= HALF_M1;
          end
        end
        RX_START: begin
          if (w_expire) begin
            if (!w_rxs) begin
              r_state <= RX_DATA;
              r_cnt   <= BIT_M1;
              r_idx   <= 3'd0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (w_expire) begin
            r_shift <= {w_rxs, r_shift[CHAR_W-1:1]};
            r_cnt   <= BIT_M1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (w_expire) begin
            r_state <= w_rxs ? RX_IDLE : RX_BREAK;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RX_BREAK: begin
          if (w_rxs) begin
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  lc3_sync_fifo #(
    .WIDTH      (CHAR_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld   <= 1'b0;
      r_char <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ld <= w_pop;
      if (w_pop) begin
        r_char <= w_head;
      end
      // A new error event wins over a coincident clear.
      r_ovr  <= (w_push && w_full) || (r_ovr && !clr_err);
      r_ferr <= w_bad_stop || (r_ferr && !clr_err);
    end
  end

  assign I_char     = r_char;
  assign LD_char    = r_ld;
  assign overrun    = r_ovr;
  assign frame_err  = r_ferr;
  assign fifo_count = w_count;

endmodule

// File: doc/lc3_uart_kb_rx.md
# lc3_uart_kb_rx

Serial keyboard front end for the LC-3 memory-mapped keyboard registers. It receives 8N1 asynchronous serial characters on `rx` and buffers them in a small FIFO. It delivers them one at a time to the keyboard data/status register stage through a one-cycle `LD_char` strobe with `I_char`. Delivery is gated on that stage's ready bit (KBSR[15]), so typed-ahead characters are never overwritten before the LC-3 program reads KBDR.

## Interface
- `DIV`, 434: clock cycles per serial bit (50 MHz / 115200). Legal range 4..65535.
- `DEPTH_LOG2`, 2: FIFO depth is 2^DEPTH_LOG2 entries (default 4).
- `clk`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `rx`  in  1  asynchronous serial line, idle high.
- `kb_full`  in  1  KBSR[15] from the keyboard register stage; 1 = previous character not yet read.
- `clr_err`  in  1  one-cycle pulse; clears `overrun` and `frame_err`.
- `I_char`  out  8  character presented with `LD_char`; holds the last delivered value otherwise.
- `LD_char`  out  1  one-cycle load strobe to the keyboard register stage.
- `overrun`  out  1  sticky; a received byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `fifo_count`  out  DEPTH_LOG2+1  current FIFO occupancy, for debug and status.

## Operation
- `rx` passes through a 2-flop synchronizer (value reset to 1). All receiver decisions use the synchronized value `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK. There is one baud counter (16 bit) and a bit index (3 bit).
- IDLE: on `rxs`==0, go to START and load the counter with DIV/2−1 (integer division).
- START: when the counter reaches 0, sample `rxs`.
  - 0: go to DATA with counter=DIV−1 and index=0.
  - 1: false start; return to IDLE with no error.
- DATA: at each counter expiry, shift `rxs` in LSB-first and reload DIV−1. After index 7, go to STOP.
- STOP: at expiry, sample `rxs`.
  - 1: push the byte and return to IDLE.
  - 0: discard the byte, set `frame_err`, and go to BREAK.
- BREAK: wait for `rxs`==1, then go to IDLE.
- FIFO: circular buffer with DEPTH_LOG2-bit read/write pointers that wrap naturally, plus a separate count.
- Push when full: the byte is dropped, `overrun` is set, and pointers are unchanged. A pop in the same cycle does not make room for that push.
- Delivery rule: assert `LD_char` in a cycle iff all of the following hold:
  - FIFO is non-empty;
  - `kb_full`==0;
  - `LD_char` was 0 in the previous cycle (a one-cycle holdoff covers KBSR[15] updating one edge later).
- On `LD_char`, `I_char` is the FIFO head and the pop happens on the same edge.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- `clr_err` clears both sticky flags. If an error event occurs in the same cycle as `clr_err`, the flag ends up set.
- Reset mid-frame: the FSM returns to IDLE and the partial byte is lost. A low `rx` still present after reset is treated as a new start bit.

## Timing
- Reset values:
  - `I_char`=0x00, `LD_char`=0, `overrun`=0, `frame_err`=0, `fifo_count`=0.
  - FSM=IDLE, pointers=0, synchronizer=1.
- Start detection lags the rx pin by 2 cycles (synchronizer).
- Data bit k is sampled DIV/2 + (k+1)·DIV cycles after the synchronized falling edge. The stop bit is sampled at DIV/2 + 9·DIV.
- The push lands on the stop-sample edge. The earliest `LD_char` is the next cycle.
- Maximum delivery rate is one `LD_char` per 2 cycles, and only while `kb_full` stays 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `lc3_kb_pkg`:
  - FSM state enum: IDLE/START/DATA/STOP/BREAK.
  - Default `DIV` constant.
  - `CHAR_W`=8.
- One natural sub-module, `lc3_sync_fifo`, parameterised by width and DEPTH_LOG2. It has push/pop/full/empty/count and drop-on-full behaviour.
- The top level holds the synchronizer, the receiver FSM and the delivery logic.

## Test plan
- DIV=8, send 0x41 with valid stop, `kb_full`=0 → exactly one `LD_char`, `I_char`=0x41, 1 cycle after the stop sample; `fifo_count` returns to 0.
- Hold `kb_full`=1, send 0x31, 0x32, 0x33, then release `kb_full` and model KBSR updating one edge after each `LD_char` and clearing 4 cycles later → three deliveries in order 0x31, 0x32, 0x33, never on consecutive cycles.
- `kb_full`=1, send 5 bytes 0x10..0x14 with DEPTH_LOG2=2 → `fifo_count`=4, `overrun`=1, 0x14 dropped. Pulse `clr_err` → `overrun`=0.
- Send 0x55 with stop bit low, then hold `rx` low for 20 bit times → no push, `frame_err`=1, FSM stays in BREAK until `rx` is high. The next valid 0x66 is delivered.
- `rx` low glitch of DIV/4 cycles → no byte and no error. `reset` asserted during DATA → all outputs return to reset values, and a following clean 0x7A is received correctly.
